// File: rtl/lcd_master_0_st_channel_arbiter.sv
// Packet-locked round-robin arbiter merging four Avalon-ST sources into one
// registered output stream; out_channel carries the granted source index.
module lcd_master_0_st_channel_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [7:0]               out_channel,
  output logic                     busy
);

  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t            state_reg;
  logic [GW-1:0]     grant_reg;
  logic [GW-1:0]     last_reg;
  logic              busy_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_sop_reg;
  logic              out_eop_reg;
  logic [7:0]        out_channel_reg;

  logic [DATA_W-1:0] src_data [NUM_IN];
  logic [GW-1:0]     rr_pick;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_sop;
  logic              sel_eop;

  // First requester after the previously served source, wrapping back to it last.
  function automatic logic [GW-1:0] rr_next(input logic [NUM_IN-1:0] req,
                                            input logic [GW-1:0]     last);
    logic [GW-1:0] idx;
    logic [GW-1:0] pick;
    logic          found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = last + GW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
      assign src_data[gi] = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi] = (state_reg == LOCKED) && (grant_reg == GW'(gi)) &&
                            (out_ready || !out_valid_reg);
    end
  endgenerate

  assign rr_pick  = rr_next(in_valid, last_reg);
  assign sel_data = src_data[grant_reg];
  assign sel_sop  = in_startofpacket[grant_reg];
  assign sel_eop  = in_endofpacket[grant_reg];
  assign accept   = (state_reg == LOCKED) && in_valid[grant_reg] && in_ready[grant_reg];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      last_reg        <= GW'(NUM_IN - 1);
      busy_reg        <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_sop_reg     <= 1'b0;
      out_eop_reg     <= 1'b0;
      out_channel_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|in_valid) begin
            grant_reg <= rr_pick;
            state_reg <= LOCKED;
            busy_reg  <= 1'b1;
          end
        end
        LOCKED: begin
          // The grant is held until the EOP beat itself is accepted, even
          // if the source goes quiet mid-packet.
          if (accept && sel_eop) begin
            state_reg <= IDLE;
            last_reg  <= grant_reg;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (accept) begin
        out_valid_reg   <= 1'b1;
        out_data_reg    <= sel_data;
        out_sop_reg     <= sel_sop;
        out_eop_reg     <= sel_eop;
        out_channel_reg <= 8'(grant_reg);
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid         = out_valid_reg;
  assign out_data          = out_data_reg;
  assign out_startofpacket = out_sop_reg;
  assign out_endofpacket   = out_eop_reg;
  assign out_channel       = out_channel_reg;
  assign busy              = busy_reg;

endmodule

// File: tb/tb_lcd_master_0_st_channel_arbiter.sv
// Scoreboard bench for the packet-locked channel arbiter: per-source beat queues
// feed the DUT, expected output beats are queued in the order the arbiter must serve them.
module tb_lcd_master_0_st_channel_arbiter;

  typedef struct packed {
    logic [1:0] ch;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_startofpacket;
  logic [3:0]  in_endofpacket;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [7:0]  out_channel;
  logic        busy;

  beat_t src_q [4][$];
  beat_t exp_q [$];
  int    acc_log [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [3:0] hold = 4'b0000;
  logic       ordy = 1'b1;
  logic [3:0] seen_ready;

  lcd_master_0_st_channel_arbiter #(.NUM_IN(4), .DATA_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_channel(out_channel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // n beats to source src; only the first n_exp are expected to emerge.
  task automatic push_pkt(input int src, input int n, input logic [7:0] base,
                          input logic [7:0] step, input int n_exp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.ch   = 2'(src);
      b.sop  = (k == 0);
      b.eop  = (k == n - 1);
      b.data = 8'(base + k * step);
      src_q[src].push_back(b);
      if (k < n_exp) exp_q.push_back(b);
    end
  endtask

  function automatic bit all_done();
    return exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
           src_q[2].size() == 0 && src_q[3].size() == 0 && !out_valid;
  endfunction

  // One clock: drive at negedge, sample just before posedge, return at next negedge.
  task automatic cycle();
    logic [3:0] acc;
    beat_t e;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        in_valid[i]         = 1'b1;
        in_data[8*i +: 8]   = src_q[i][0].data;
        in_startofpacket[i] = src_q[i][0].sop;
        in_endofpacket[i]   = src_q[i][0].eop;
      end else begin
        in_valid[i]         = 1'b0;
        in_data[8*i +: 8]   = 8'h00;
        in_startofpacket[i] = 1'b0;
        in_endofpacket[i]   = 1'b0;
      end
    end
    out_ready = ordy;
    #4;
    acc        = in_valid & in_ready;
    seen_ready = in_ready;
    checks++;
    if ($countones(in_ready) > 1) begin
      errors++;
      $display("FAIL in_ready_onehot cyc=%0d got=%b required at most one bit", cyc, in_ready);
    end
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d got ch=%0d data=%h required no beat",
                 cyc, out_channel, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_channel, out_startofpacket, out_endofpacket, out_data} !==
            {6'b0, e.ch, e.sop, e.eop, e.data}) begin
          errors++;
          $display("FAIL out_beat cyc=%0d got ch=%0d sop=%b eop=%b data=%h required ch=%0d sop=%b eop=%b data=%h",
                   cyc, out_channel, out_startofpacket, out_endofpacket, out_data,
                   e.ch, e.sop, e.eop, e.data);
        end else begin
          $display("beat cyc=%0d ch=%0d sop=%b eop=%b data=%h", cyc, out_channel,
                   out_startofpacket, out_endofpacket, out_data);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        acc_log.push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_drain(input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      if (all_done()) break;
      cycle();
    end
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL %s_drain got %0d beats outstanding required 0", name, exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset_n          = 1'b0;
    in_valid         = 4'b0000;
    in_data          = 32'h0;
    in_startofpacket = 4'b0000;
    in_endofpacket   = 4'b0000;
    ordy             = 1'b1;
    out_ready        = 1'b1;
    hold             = 4'b0000;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    acc_log.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, out_startofpacket, out_endofpacket} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got valid=%b busy=%b sop=%b eop=%b required 0",
               out_valid, busy, out_startofpacket, out_endofpacket);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 0000", in_ready);
    end
    checks++;
    if (out_data !== 8'h00 || out_channel !== 8'h00) begin
      errors++;
      $display("FAIL reset_fields got data=%h ch=%h required 00 00", out_data, out_channel);
    end
    $display("reset checked");
    apply_reset();
  endtask

  task automatic test_two_sources();
    apply_reset();
    push_pkt(1, 2, 8'h10, 8'h01, 2);
    push_pkt(3, 2, 8'h30, 8'h01, 2);
    run_drain(40, "two_sources");
  endtask

  task automatic test_round_robin();
    int start;
    apply_reset();
    push_pkt(0, 2, 8'h00, 8'h01, 2);
    push_pkt(1, 2, 8'h10, 8'h01, 2);
    push_pkt(2, 2, 8'h20, 8'h01, 2);
    push_pkt(3, 2, 8'h30, 8'h01, 2);
    push_pkt(0, 2, 8'h04, 8'h01, 2);
    start = cyc;
    run_drain(60, "round_robin");
    checks++;
    if (acc_log.size() != 10) begin
      errors++;
      $display("FAIL rr_accept_count got %0d required 10", acc_log.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (acc_log[k] != start + 1 + (k / 2) * 3 + (k % 2)) begin
          errors++;
          $display("FAIL rr_accept_cycle beat=%0d got %0d required %0d", k,
                   acc_log[k] - start, 1 + (k / 2) * 3 + (k % 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int stall;
    apply_reset();
    push_pkt(2, 4, 8'h11, 8'h11, 4);
    stall = 0;
    for (int n = 0; n < 40 && !all_done(); n++) begin
      if (out_valid && out_data == 8'h22 && stall < 3) begin
        ordy = 1'b0;
        stall++;
        cycle();
        checks++;
        if (seen_ready[2] !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready stall=%0d got %b required 0", stall, seen_ready[2]);
        end
      end else begin
        ordy = 1'b1;
        cycle();
      end
    end
    ordy = 1'b1;
    checks++;
    if (stall != 3) begin
      errors++;
      $display("FAIL stall_count got %0d required 3", stall);
    end
    run_drain(20, "backpressure");
  endtask

  task automatic test_hold_mid_packet();
    apply_reset();
    push_pkt(1, 3, 8'h60, 8'h01, 3);
    cycle();
    cycle();
    hold[1] = 1'b1;
    push_pkt(0, 1, 8'h70, 8'h01, 1);
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++;
      if (busy !== 1'b1 || seen_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_grant got busy=%b ready0=%b required busy=1 ready0=0",
                 busy, seen_ready[0]);
      end
    end
    hold[1] = 1'b0;
    run_drain(30, "hold");
  endtask

  task automatic test_single_beat();
    apply_reset();
    push_pkt(0, 1, 8'hA5, 8'h01, 1);
    cycle();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_grant got %b required 1", busy);
    end
    cycle();
    checks++;
    if ({busy, out_valid, out_startofpacket, out_endofpacket, out_data} !== {4'b0111, 8'hA5}) begin
      errors++;
      $display("FAIL single_beat got busy=%b valid=%b sop=%b eop=%b data=%h required 0 1 1 1 a5",
               busy, out_valid, out_startofpacket, out_endofpacket, out_data);
    end
    run_drain(10, "single");
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    push_pkt(1, 5, 8'h51, 8'h01, 1);
    repeat (3) cycle();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b1 || out_data !== 8'h52) begin
      errors++;
      $display("FAIL midpkt_pre got pending=%0d valid=%b data=%h required 0 1 52",
               exp_q.size(), out_valid, out_data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 6'b000000) begin
      errors++;
      $display("FAIL midpkt_reset got valid=%b busy=%b ready=%b required 0 0 0000",
               out_valid, busy, in_ready);
    end
    for (int i = 0; i < 4; i++) src_q[i].delete();
    in_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push_pkt(0, 1, 8'h80, 8'h01, 1);
    push_pkt(1, 1, 8'h90, 8'h01, 1);
    run_drain(20, "after_reset");
  endtask

  initial begin
    reset_n          = 1'b0;
    in_valid         = 4'b0000;
    in_data          = 32'h0;
    in_startofpacket = 4'b0000;
    in_endofpacket   = 4'b0000;
    out_ready        = 1'b1;
    @(negedge clk);
    test_reset();
    test_two_sources();
    test_round_robin();
    test_backpressure();
    test_hold_mid_packet();
    test_single_beat();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
